sdram_arbiter: RTL



---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_arbiter_if.sv | 39 +++
 rtl/sdram_arbiter_refresh_timer.sv | 45 ++++
 rtl/sdram_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM command-port arbiter.
//   ADDR_W           burst address width (bank+row+column)
//   REFRESH_INTERVAL clk cycles between auto-refresh requests
//   MAX_DISP_RUN     display grants allowed back-to-back while life waits
//   owner_t          which requester owns the in-flight command
//   state_t          arbiter FSM states
package sdram_pkg;

    localparam int ADDR_W           = 23;
    localparam int REFRESH_INTERVAL = 1040;
    localparam int MAX_DISP_RUN     = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_REFRESH,
        OWN_DISP,
        OWN_LIFE
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester and controller signals of the SDRAM arbiter.
//   Display requester : dispReq, dispAddr -> dispGrant, dispDone
//   Life requester    : lifeReq, lifeWe, lifeAddr -> lifeGrant, lifeDone
//   Controller        : memCmdValid/Ready, memCmdAddr, memCmdWe,
//                       memCmdRefresh, memDone
//   Status            : refreshOverrun (sticky)
// master = arbiter view, slave = requesters/controller view.
interface sdram_arbiter_if #(
    parameter int ADDR_W = sdram_pkg::ADDR_W
);
    logic              dispReq;
    logic [ADDR_W-1:0] dispAddr;
    logic              dispGrant;
    logic              dispDone;
    logic              lifeReq;
    logic              lifeWe;
    logic [ADDR_W-1:0] lifeAddr;
    logic              lifeGrant;
    logic              lifeDone;
    logic              memCmdValid;
    logic              memCmdReady;
    logic [ADDR_W-1:0] memCmdAddr;
    logic              memCmdWe;
    logic              memCmdRefresh;
    logic              memDone;
    logic              refreshOverrun;

    modport master (
        input  dispReq, dispAddr, lifeReq, lifeWe, lifeAddr, memCmdReady, memDone,
        output dispGrant, dispDone, lifeGrant, lifeDone,
        output memCmdValid, memCmdAddr, memCmdWe, memCmdRefresh, refreshOverrun
    );

    modport slave (
        output dispReq, dispAddr, lifeReq, lifeWe, lifeAddr, memCmdReady, memDone,
        input  dispGrant, dispDone, lifeGrant, lifeDone,
        input  memCmdValid, memCmdAddr, memCmdWe, memCmdRefresh, refreshOverrun
    );
endinterface

// File: rtl/sdram_arbiter_refresh_timer.sv
// refresh_timer: free-running auto-refresh interval timer.
//   clk, rst   memory clock, synchronous active-high reset
//   i_ack      refresh command accepted by the controller
//   o_pending  a refresh is owed
//   o_overrun  sticky: interval expired while a refresh was still owed
module refresh_timer #(
    parameter int REFRESH_INTERVAL = 1040
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ack,
    output logic o_pending,
    output logic o_overrun
);
    localparam int CNT_W = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_overrun;
    logic             w_expire;

    assign w_expire = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= RELOAD;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt <= w_expire ? RELOAD : r_cnt - 1'b1;
            // Expiry wins over an acknowledge in the same cycle.
            if (w_expire) begin
                r_pending <= 1'b1;
                if (r_pending)
                    r_overrun <= 1'b1;
            end else if (i_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM command port between the display fetch,
// the game-of-life updater and periodic auto-refresh. One command in flight.
//   clk, rst  memory clock, synchronous active-high reset
//   bus       sdram_arbiter_if.master (requester, controller, status signals)
// Priority in IDLE: refresh, starved life, display, life.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = sdram_pkg::REFRESH_INTERVAL,
    parameter int MAX_DISP_RUN     = sdram_pkg::MAX_DISP_RUN
) (
    input  logic            clk,
    input  logic            rst,
    sdram_arbiter_if.master bus
);
    localparam int RUN_W = $clog2(MAX_DISP_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DISP_RUN);

    state_t            r_state;
    state_t            w_next_state;
    owner_t            r_owner;
    owner_t            w_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              r_we;
    logic              w_sel_we;
    logic [RUN_W-1:0]  r_dispRun;
    logic              r_dispDone;
    logic              r_lifeDone;
    logic              w_accept;
    logic              w_refreshPending;
    logic              w_refreshOverrun;

    refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk      (clk),
        .rst      (rst),
        .i_ack    (w_accept && (r_owner == OWN_REFRESH)),
        .o_pending(w_refreshPending),
        .o_overrun(w_refreshOverrun)
    );

    assign w_accept = (r_state == ST_ISSUE) && bus.memCmdReady;

    always_comb begin
        w_next_state = r_state;
        w_sel        = OWN_NONE;
        w_sel_addr   = '0;
        w_sel_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_refreshPending) begin
                    w_sel = OWN_REFRESH;
                end else if (bus.lifeReq && (r_dispRun == RUN_MAX)) begin
                    w_sel = OWN_LIFE;
                end else if (bus.dispReq) begin
                    w_sel = OWN_DISP;
                end else if (bus.lifeReq) begin
                    w_sel = OWN_LIFE;
                end
                if (w_sel == OWN_DISP) begin
                    w_sel_addr = bus.dispAddr;
                end else if (w_sel == OWN_LIFE) begin
                    w_sel_addr = bus.lifeAddr;
                    w_sel_we   = bus.lifeWe;
                end
                if (w_sel != OWN_NONE)
                    w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.memCmdReady)
                    w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.memDone)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OWN_NONE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_dispRun  <= '0;
            r_dispDone <= 1'b0;
            r_lifeDone <= 1'b0;
        end else begin
            r_dispDone <= (r_state == ST_WAIT_DONE) && bus.memDone && (r_owner == OWN_DISP);
            r_lifeDone <= (r_state == ST_WAIT_DONE) && bus.memDone && (r_owner == OWN_LIFE);

            if (w_sel != OWN_NONE) begin
                r_owner <= w_sel;
                r_addr  <= w_sel_addr;
                r_we    <= w_sel_we;
            end

            // Consecutive display grants with life waiting; saturating.
            if (w_accept && (r_owner == OWN_LIFE)) begin
                r_dispRun <= '0;
            end else if (w_accept && (r_owner == OWN_DISP) && bus.lifeReq) begin
                if (r_dispRun != RUN_MAX)
                    r_dispRun <= r_dispRun + 1'b1;
            end else if ((r_state == ST_IDLE) && !bus.lifeReq) begin
                r_dispRun <= '0;
            end
        end
    end

    assign bus.memCmdValid    = (r_state == ST_ISSUE);
    assign bus.memCmdAddr     = r_addr;
    assign bus.memCmdWe       = r_we;
    assign bus.memCmdRefresh  = (r_state == ST_ISSUE) && (r_owner == OWN_REFRESH);
    assign bus.dispGrant      = w_accept && (r_owner == OWN_DISP);
    assign bus.lifeGrant      = w_accept && (r_owner == OWN_LIFE);
    assign bus.dispDone       = r_dispDone;
    assign bus.lifeDone       = r_lifeDone;
    assign bus.refreshOverrun = w_refreshOverrun;
endmodule
